// File: rtl/coeff_bank_if.sv
// Host load stream and filter-bank coefficient read bus for coeff_bank.
// The bank is the slave side; the host/filter bank drives the master side.
interface coeff_bank_if #(
  parameter int NFILT = 8,
  parameter int AW    = 6,
  parameter int CW    = 36
);
  logic                       load_start;
  logic [CW-1:0]              load_data;
  logic                       load_valid;
  logic                       load_ready;
  logic                       load_done;
  logic                       coef_valid;
  logic [AW-1:0]              coeffaddress;
  logic [NFILT-1:0][CW-1:0]   coeff;

  modport master (
    output load_start, load_data, load_valid, coeffaddress,
    input  load_ready, load_done, coef_valid, coeff
  );

  modport slave (
    input  load_start, load_data, load_valid, coeffaddress,
    output load_ready, load_done, coef_valid, coeff
  );
endinterface

// File: rtl/coeff_bank.sv
// Coefficient bank for the 8-channel FIR: streamed 512-word load, then a
// 1-cycle registered read of all filters at one address, gated to zero until loaded.
module coeff_lane #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [CW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          gate_i,
  output logic [CW-1:0] rdata_o
);
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] rdata_q;

  // Storage has no reset; stale contents are hidden by the output gate.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata_q <= '0;
    else if (gate_i) rdata_q <= mem[raddr_i];
    else             rdata_q <= '0;
  end

  assign rdata_o = rdata_q;
endmodule

module coeff_bank #(
  parameter int NFILT = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  coeff_bank_if.slave bus
);
  localparam int WW = $clog2(NFILT * DEPTH);
  localparam logic [WW-1:0] LAST = WW'(NFILT * DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_e;

  state_e                    state_q, state_d;
  logic [WW-1:0]             wcnt_q, wcnt_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      we;
  logic [NFILT-1:0]          lane_we;
  logic [NFILT-1:0][CW-1:0]  coeff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // A restart always beats an accept, including the final word.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
          wcnt_d  = '0;
          valid_d = 1'b0;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          wcnt_d  = '0;
          valid_d = 1'b0;
        end else if (bus.load_valid) begin
          we     = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_we = '0;
    lane_we[wcnt_q[WW-1:AW]] = we;
  end

  for (genvar g = 0; g < NFILT; g++) begin : g_lane
    coeff_lane #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (lane_we[g]),
      .waddr_i (wcnt_q[AW-1:0]),
      .wdata_i (bus.load_data),
      .raddr_i (bus.coeffaddress),
      .gate_i  (valid_q),
      .rdata_o (coeff[g])
    );
  end

  assign bus.coeff      = coeff;
  assign bus.load_ready = (state_q == LOAD);
  assign bus.load_done  = done_q;
  assign bus.coef_valid = valid_q;
endmodule

// File: doc/coeff_bank.md
# coeff_bank

Coefficient memory bank for the 8-channel FIR filter bank. It is loaded once, or reloaded at any time, from a host word stream with a valid/ready handshake. It then serves as the read responder on the filter bank's shared coefficient address bus: one address in, eight 36-bit coefficients out one clock later. Coefficient outputs are forced to zero until a complete, uninterrupted load has finished, so the filter bank produces zeros until it is configured.

## Interface
- NFILT, 8: number of filters / coefficient outputs (fixed, not to be overridden)
- DEPTH, 64: coefficients per filter
- AW, 6: coefficient address width (log2 DEPTH)
- CW, 36: coefficient word width
- clock  in  1  master clock, rising edge
- reset  in  1  master reset; one clock; reset is asynchronous and active-low
- load_start  in  1  one-cycle pulse that starts (or restarts) a full 512-word load
- load_data  in  CW  coefficient word from host, signed
- load_valid  in  1  load_data is valid this cycle
- load_ready  out  1  bank accepts a word this cycle (high only in LOAD)
- load_done  out  1  one-cycle pulse after the last word is written
- coef_valid  out  1  bank holds a complete coefficient set
- coeffaddress  in  AW  read address from the filter bank
- coeff0..coeff7  out  CW each  signed coefficient of filter 0..7 at the registered address

## Operation
- Storage: 8 arrays of DEPTH x CW. Memory contents are not reset.
- FSM states:
  - IDLE: load_ready=0.
  - LOAD: load_ready=1.
- IDLE -> LOAD on load_start. This clears the 9-bit word counter wcnt and clears coef_valid.
- In LOAD, a word is accepted when load_valid & load_ready. It is written to mem[wcnt[8:6]][wcnt[5:0]], then wcnt increments.
- Load order: filter 0 addresses 0..63, then filter 1, and so on through filter 7. Word k goes to filter k/64, address k%64.
- LOAD -> IDLE on the 512th accepted word (wcnt==511 & accept). On that transition, load_done=1 for one cycle and coef_valid is set.
- load_start during LOAD restarts the load: wcnt=0, coef_valid stays 0, state stays LOAD. If load_start and the final accept occur in the same cycle, the restart wins: the word is not written, and there is no load_done.
- load_start while in IDLE with coef_valid=1 clears coef_valid and begins a reload.
- load_valid in IDLE is ignored and produces no write.
- Read port: registered. When coef_valid=1, coeffN <= mem[N][coeffaddress]; otherwise coeffN <= 0.
- Read and write to the same location in the same cycle never produces visible data, because outputs are zero while coef_valid=0.
- Coefficients pass through unchanged (full 36-bit, no scaling or truncation).

## Timing
- Reset (asserted low, asynchronous) forces:
  - state IDLE, wcnt 0
  - load_ready 0, load_done 0, coef_valid 0
  - coeff0..coeff7 = 0
- Memory keeps stale data after reset, but outputs stay gated until the next completed load.
- Deassertion of reset is synchronized externally. The first active edge after deassertion may be a load_start.
- load_start sampled at edge t gives load_ready=1 from t+1.
- The final accept at edge t gives load_ready=0, load_done=1 and coef_valid=1 from t+1. load_done drops at t+2.
- Read latency is 1 clock: coeffaddress sampled at edge t appears on coeffN after edge t. This matches the filter bank, which presents an address and uses the data on the following cycle.
- The first non-zero coefficient can appear at t+2 after the final accept (coef_valid is sampled at t+1).
- Throughput: one word per clock with load_valid held high, so a minimum of 512 cycles per load.
- Reset mid-load aborts immediately. The partially written memory remains, but coef_valid=0, so outputs stay 0.

## Test plan
- Reset low with random inputs -> all coeffN=0, load_ready=0, load_done=0, coef_valid=0. Drive coeffaddress 0..63 -> outputs remain 0.
- load_start, then 512 back-to-back words with data=k (k=0..511) -> load_done exactly one cycle after the 512th word, coef_valid=1. Then coeffaddress=5 -> next cycle coeff0=5, coeff3=197, coeff7=453.
- Same load with load_valid toggling every other cycle -> only handshaken words are counted; contents identical to the previous scenario; load_done one cycle after the 512th accept (about 1023 cycles).
- After 100 words, pulse load_start, then load 512 words with data=1000+k -> no load_done until the second load completes; coeff1 at address 0 = 1064.
- Reset low after 300 words -> outputs and flags drop asynchronously, state IDLE, load_valid ignored. A subsequent full load gives correct contents.
- With coef_valid=1, pulse load_start -> coef_valid=0 next cycle and coeffN=0 from the following cycle until the new load_done. Include load_start coinciding with the 512th word -> no load_done, wcnt restarts at 0.
